// File: rtl/battle_turn_scheduler_if.sv
// Bundles the move-select/datapath handshake seen by the battle turn scheduler.
// Latency: none, wires only.
// Backpressure: dmg_done from the datapath is the only flow control on apply_damage.
interface battle_turn_scheduler_if #(
    parameter int SPD_W  = 8,
    parameter int HP_W   = 8,
    parameter int TURN_W = 8
);
    logic              go;
    logic [SPD_W-1:0]  p_speed;
    logic [SPD_W-1:0]  ai_speed;
    logic [HP_W-1:0]   p_hp;
    logic [HP_W-1:0]   ai_hp;
    logic              dmg_done;
    logic              apply_damage;
    logic              active_trainer;
    logic              target;
    logic              busy;
    logic              victory;
    logic              loss;
    logic [TURN_W-1:0] turn_count;

    // Front end plus datapath side: supplies stats/HP and acknowledges hits.
    modport master (
        output go, p_speed, ai_speed, p_hp, ai_hp, dmg_done,
        input  apply_damage, active_trainer, target, busy, victory, loss, turn_count
    );

    // Scheduler side.
    modport slave (
        input  go, p_speed, ai_speed, p_hp, ai_hp, dmg_done,
        output apply_damage, active_trainer, target, busy, victory, loss, turn_count
    );
endinterface

// File: rtl/battle_turn_scheduler.sv
// Runs one battle turn per go: orders attackers by speed, issues two damage hits, checks KO.
// Latency: ORDER 1 cycle, each HIT >= 1 cycle (until dmg_done), each CHECK 1 cycle; min turn 5 cycles.
// Backpressure: apply_damage is held until dmg_done; TIE_ALTERNATE_EN alternates first mover on speed ties.
module battle_turn_scheduler #(
    parameter int SPD_W  = 8,
    parameter int HP_W   = 8,
    parameter int TURN_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    battle_turn_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ORDER, HIT1, CHECK1, HIT2, CHECK2, VICTORY, LOSS
    } state_t;

    typedef struct packed {
        logic apply_damage;
        logic active_trainer;
        logic target;
        logic busy;
        logic victory;
        logic loss;
    } outs_t;

    state_t            state, state_nxt;
    logic              first_is_ai, first_nxt;
    logic [TURN_W-1:0] turn_q, turn_nxt;
    outs_t             outs_q;
    logic              ai_faster;
    logic              speed_tie;
    logic              order_first;
    logic              hit1_tgt_dead;
    logic              hit2_tgt_dead;

`ifdef TIE_ALTERNATE_EN
    logic tie_flag, tie_nxt;
`endif

    // Output image of a state; attacker/target only meaningful during a hit.
    function automatic outs_t decode(state_t s, logic fa);
        outs_t o;
        o = '0;
        case (s)
            ORDER:   o.busy = 1'b1;
            HIT1: begin
                o.apply_damage   = 1'b1;
                o.active_trainer = fa;
                o.target         = ~fa;
                o.busy           = 1'b1;
            end
            CHECK1:  o.busy = 1'b1;
            HIT2: begin
                o.apply_damage   = 1'b1;
                o.active_trainer = ~fa;
                o.target         = fa;
                o.busy           = 1'b1;
            end
            CHECK2:  o.busy = 1'b1;
            VICTORY: o.victory = 1'b1;
            LOSS:    o.loss = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    assign ai_faster = bus.ai_speed > bus.p_speed;
    assign speed_tie = bus.ai_speed == bus.p_speed;

`ifdef TIE_ALTERNATE_EN
    // Ties go to whoever the flag points at; first tie after reset is the player's.
    assign order_first = ai_faster | (speed_tie & tie_flag);
`else
    // Ties always go to the player.
    assign order_first = ai_faster;
`endif

    // HIT1 targets the AI when the player attacks first, and vice versa for HIT2.
    assign hit1_tgt_dead = (first_is_ai ? bus.p_hp  : bus.ai_hp) == '0;
    assign hit2_tgt_dead = (first_is_ai ? bus.ai_hp : bus.p_hp)  == '0;

    // Next-state, attack order and turn counter decisions.
    always_comb begin
        state_nxt = state;
        first_nxt = first_is_ai;
        turn_nxt  = turn_q;
`ifdef TIE_ALTERNATE_EN
        tie_nxt   = tie_flag;
`endif
        case (state)
            IDLE: begin
                if (bus.go) state_nxt = ORDER;
            end
            ORDER: begin
                if (bus.ai_hp == '0) begin
                    state_nxt = VICTORY;
                end else if (bus.p_hp == '0) begin
                    state_nxt = LOSS;
                end else begin
                    first_nxt = order_first;
`ifdef TIE_ALTERNATE_EN
                    tie_nxt   = tie_flag ^ speed_tie;
`endif
                    state_nxt = HIT1;
                end
            end
            HIT1: begin
                if (bus.dmg_done) state_nxt = CHECK1;
            end
            CHECK1: begin
                if (hit1_tgt_dead) state_nxt = first_is_ai ? LOSS : VICTORY;
                else               state_nxt = HIT2;
            end
            HIT2: begin
                if (bus.dmg_done) state_nxt = CHECK2;
            end
            CHECK2: begin
                if (hit2_tgt_dead) begin
                    state_nxt = first_is_ai ? VICTORY : LOSS;
                end else begin
                    state_nxt = IDLE;
                    turn_nxt  = (turn_q == {TURN_W{1'b1}}) ? turn_q : turn_q + 1'b1;
                end
            end
            VICTORY: state_nxt = VICTORY;
            LOSS:    state_nxt = LOSS;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            first_is_ai <= 1'b0;
            turn_q      <= '0;
            outs_q      <= '0;
`ifdef TIE_ALTERNATE_EN
            tie_flag    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            first_is_ai <= first_nxt;
            turn_q      <= turn_nxt;
            outs_q      <= decode(state_nxt, first_nxt);
`ifdef TIE_ALTERNATE_EN
            tie_flag    <= tie_nxt;
`endif
        end
    end

    assign bus.apply_damage   = outs_q.apply_damage;
    assign bus.active_trainer = outs_q.active_trainer;
    assign bus.target         = outs_q.target;
    assign bus.busy           = outs_q.busy;
    assign bus.victory        = outs_q.victory;
    assign bus.loss           = outs_q.loss;
    assign bus.turn_count     = turn_q;

endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Directed bench for battle_turn_scheduler: turn timing, KO endings, stall/reset, ties, saturation.
// Latency: checks sampled on the falling edge, cycle n = after rising edge n-1 from go sample.
// Backpressure: dmg_done driven directly by the bench to model immediate or stalled datapath.
module tb_battle_turn_scheduler;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    battle_turn_scheduler_if #(.SPD_W(8), .HP_W(8), .TURN_W(8)) bus ();

    battle_turn_scheduler #(.SPD_W(8), .HP_W(8), .TURN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {apply_damage, active_trainer, target, busy, victory, loss}
    logic [5:0] o6;
    // {apply_damage, busy, victory, loss}
    logic [3:0] o4;
    assign o6 = {bus.apply_damage, bus.active_trainer, bus.target, bus.busy, bus.victory, bus.loss};
    assign o4 = {bus.apply_damage, bus.busy, bus.victory, bus.loss};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // go pulse; returns at cycle 1 (ORDER).
    task automatic pulse_go();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Full turn with dmg_done held high; returns at cycle 6.
    task automatic run_turn();
        pulse_go();
        repeat (5) step();
    endtask

    task automatic test_reset();
        step();
        n_cmp++;
        if (o6 !== 6'b000000) begin
            n_err++; $display("FAIL reset_outs: got %b want 000000", o6);
        end
        n_cmp++;
        if (bus.turn_count !== 8'd0) begin
            n_err++; $display("FAIL reset_turn: got %0d want 0", bus.turn_count);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (o6 !== 6'b000000) begin
            n_err++; $display("FAIL idle_outs: got %b want 000000", o6);
        end
    endtask

    task automatic test_player_faster();
        bus.p_speed = 8'd50; bus.ai_speed = 8'd30;
        bus.p_hp = 8'd100; bus.ai_hp = 8'd100;
        bus.dmg_done = 1'b1;
        pulse_go();
        n_cmp++;
        if (o4 !== 4'b0100) begin
            n_err++; $display("FAIL pf_order: got %b want 0100", o4);
        end
        step();
        n_cmp++;
        if (o6 !== 6'b101100) begin
            n_err++; $display("FAIL pf_hit1: got %b want 101100", o6);
        end
        step();
        n_cmp++;
        if (o4 !== 4'b0100) begin
            n_err++; $display("FAIL pf_check1: got %b want 0100", o4);
        end
        step();
        n_cmp++;
        if (o6 !== 6'b110100) begin
            n_err++; $display("FAIL pf_hit2: got %b want 110100", o6);
        end
        step();
        n_cmp++;
        if (o4 !== 4'b0100) begin
            n_err++; $display("FAIL pf_check2: got %b want 0100", o4);
        end
        step();
        n_cmp++;
        if (o4 !== 4'b0000) begin
            n_err++; $display("FAIL pf_idle: got %b want 0000", o4);
        end
        n_cmp++;
        if (bus.turn_count !== 8'd1) begin
            n_err++; $display("FAIL pf_turn: got %0d want 1", bus.turn_count);
        end
    endtask

    task automatic test_ties();
        logic [2:0] tie_exp;
`ifdef TIE_ALTERNATE_EN
        tie_exp = 3'b010;
`else
        tie_exp = 3'b000;
`endif
        bus.p_speed = 8'd40; bus.ai_speed = 8'd40;
        bus.dmg_done = 1'b1;
        for (int t = 0; t < 3; t++) begin
            pulse_go();
            step();
            n_cmp++;
            if ({bus.apply_damage, bus.active_trainer, bus.target} !== {1'b1, tie_exp[t], ~tie_exp[t]}) begin
                n_err++;
                $display("FAIL tie_first[%0d]: got apply/act/tgt %b%b%b want 1%b%b", t,
                         bus.apply_damage, bus.active_trainer, bus.target, tie_exp[t], ~tie_exp[t]);
            end
            repeat (4) step();
        end
        n_cmp++;
        if (bus.turn_count !== 8'd4) begin
            n_err++; $display("FAIL tie_turns: got %0d want 4", bus.turn_count);
        end
    endtask

    task automatic test_saturate();
        bus.p_speed = 8'd50; bus.ai_speed = 8'd30;
        bus.dmg_done = 1'b1;
        repeat (256) run_turn();
        n_cmp++;
        if (bus.turn_count !== 8'd255) begin
            n_err++; $display("FAIL turn_saturate: got %0d want 255", bus.turn_count);
        end
        n_cmp++;
        if (o4 !== 4'b0000) begin
            n_err++; $display("FAIL sat_idle: got %b want 0000", o4);
        end
    endtask

    task automatic test_stall();
        bus.p_speed = 8'd50; bus.ai_speed = 8'd30;
        bus.dmg_done = 1'b0;
        pulse_go();
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (o6 !== 6'b101100) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %b want 101100", i, o6);
            end
            bus.go = i[0];
            step();
        end
        bus.go = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (o6 !== 6'b000000) begin
            n_err++; $display("FAIL stall_reset_outs: got %b want 000000", o6);
        end
        n_cmp++;
        if (bus.turn_count !== 8'd0) begin
            n_err++; $display("FAIL stall_reset_turn: got %0d want 0", bus.turn_count);
        end
        step();
        reset = 1'b0;
        bus.dmg_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (o6 !== 6'b000000) begin
                n_err++; $display("FAIL stall_after[%0d]: got %b want 000000", i, o6);
            end
        end
        bus.dmg_done = 1'b0;
    endtask

    task automatic test_ai_ko();
        bus.p_speed = 8'd60; bus.ai_speed = 8'd10;
        bus.p_hp = 8'd100; bus.ai_hp = 8'd100;
        bus.dmg_done = 1'b0;
        pulse_go();
        step();
        n_cmp++;
        if (o6 !== 6'b101100) begin
            n_err++; $display("FAIL ako_hit1: got %b want 101100", o6);
        end
        bus.dmg_done = 1'b1;
        bus.ai_hp = 8'd0;
        step();
        bus.dmg_done = 1'b0;
        n_cmp++;
        if (o4 !== 4'b0100) begin
            n_err++; $display("FAIL ako_check1: got %b want 0100", o4);
        end
        step();
        bus.ai_hp = 8'd100;
        bus.dmg_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (o4 !== 4'b0010) begin
                n_err++; $display("FAIL ako_victory[%0d]: got %b want 0010", i, o4);
            end
            bus.go = ~i[0];
            step();
        end
        bus.go = 1'b0;
        bus.dmg_done = 1'b0;
        n_cmp++;
        if (bus.turn_count !== 8'd0) begin
            n_err++; $display("FAIL ako_turn: got %0d want 0", bus.turn_count);
        end
    endtask

    task automatic test_player_ko();
        pulse_reset();
        bus.p_speed = 8'd20; bus.ai_speed = 8'd80;
        bus.p_hp = 8'd100; bus.ai_hp = 8'd100;
        pulse_go();
        step();
        n_cmp++;
        if (o6 !== 6'b110100) begin
            n_err++; $display("FAIL pko_hit1: got %b want 110100", o6);
        end
        bus.dmg_done = 1'b1;
        bus.p_hp = 8'd0;
        step();
        bus.dmg_done = 1'b0;
        n_cmp++;
        if (o4 !== 4'b0100) begin
            n_err++; $display("FAIL pko_check1: got %b want 0100", o4);
        end
        step();
        bus.p_hp = 8'd100;
        bus.dmg_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (o4 !== 4'b0001) begin
                n_err++; $display("FAIL pko_loss[%0d]: got %b want 0001", i, o4);
            end
            bus.go = ~i[0];
            step();
        end
        bus.go = 1'b0;
        bus.dmg_done = 1'b0;
    endtask

    task automatic test_pre_dead();
        pulse_reset();
        bus.p_hp = 8'd0; bus.ai_hp = 8'd0;
        bus.dmg_done = 1'b1;
        pulse_go();
        n_cmp++;
        if (o4 !== 4'b0100) begin
            n_err++; $display("FAIL dead_order: got %b want 0100", o4);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (o4 !== 4'b0010) begin
                n_err++; $display("FAIL dead_victory[%0d]: got %b want 0010", i, o4);
            end
        end
        bus.dmg_done = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.go = 1'b0;
        bus.p_speed = '0;
        bus.ai_speed = '0;
        bus.p_hp = 8'd100;
        bus.ai_hp = 8'd100;
        bus.dmg_done = 1'b0;

        test_reset();
        test_player_faster();
        test_ties();
        test_saturate();
        test_stall();
        test_ai_ko();
        test_player_ko();
        test_pre_dead();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
